// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding read to a fixed-latency memory,
// with a one-entry output holding register and flush on redirect.
//
// state  | meaning
// IDLE   | no fetch outstanding, ready for a request
// WAIT   | read issued, counting memory latency
// HOLD   | instruction held until decode accepts it
module fetch_unit #(
    parameter int READ_LAT = 3,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic              req,
    output logic              req_ready,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_dout,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              addr_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Data is captured one edge after it becomes valid, so the compare value is
    // READ_LAT itself; with READ_LAT<=15 the 4-bit counter never wraps.
    localparam logic [3:0] LAT_CNT = 4'(READ_LAT);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       pc_out_of_range;

    assign req_ready       = (state == S_IDLE) || ((state == S_HOLD) && instr_ready && !flush);
    assign pc_out_of_range = (pc >> ADDR_W) != 32'd0;
    assign mem_wen         = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            instr       <= 32'd0;
            instr_pc    <= 32'd0;
            instr_valid <= 1'b0;
            mem_en      <= 1'b0;
            mem_ren     <= 1'b0;
            mem_addr    <= '0;
            addr_err    <= 1'b0;
        end else if (flush) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            instr_valid <= 1'b0;
            mem_en      <= 1'b0;
            mem_ren     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state    <= S_WAIT;
                        cnt      <= 4'd0;
                        mem_addr <= pc[ADDR_W-1:0];
                        instr_pc <= pc;
                        mem_en   <= 1'b1;
                        mem_ren  <= 1'b1;
                        if (pc_out_of_range) addr_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == LAT_CNT) begin
                        state       <= S_HOLD;
                        instr       <= mem_dout;
                        instr_valid <= 1'b1;
                        mem_en      <= 1'b0;
                        mem_ren     <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (req) begin
                            // Hand-off and next issue share one edge: no idle bubble.
                            state    <= S_WAIT;
                            cnt      <= 4'd0;
                            mem_addr <= pc[ADDR_W-1:0];
                            instr_pc <= pc;
                            mem_en   <= 1'b1;
                            mem_ren  <= 1'b1;
                            if (pc_out_of_range) addr_err <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: three instances (READ_LAT 3, 1, 15) on shared
// stimulus, each backed by a fixed-latency memory model and a result scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        req;
    logic        flush;
    logic        instr_ready;

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    logic        d3_rr, d3_en, d3_ren, d3_wen, d3_valid, d3_err;
    logic [15:0] d3_addr;
    logic [31:0] d3_dout, d3_instr, d3_ipc;
    logic        d1_rr, d1_en, d1_ren, d1_wen, d1_valid, d1_err;
    logic [15:0] d1_addr;
    logic [31:0] d1_dout, d1_instr, d1_ipc;
    logic        d15_rr, d15_en, d15_ren, d15_wen, d15_valid, d15_err;
    logic [15:0] d15_addr;
    logic [31:0] d15_dout, d15_instr, d15_ipc;

    fetch_unit #(.READ_LAT(3), .ADDR_W(16)) u_dut (
        .clk(clk), .reset(reset), .pc(pc), .req(req), .req_ready(d3_rr), .flush(flush),
        .mem_en(d3_en), .mem_ren(d3_ren), .mem_wen(d3_wen), .mem_addr(d3_addr),
        .mem_dout(d3_dout), .instr(d3_instr), .instr_pc(d3_ipc), .instr_valid(d3_valid),
        .instr_ready(instr_ready), .addr_err(d3_err));

    fetch_unit #(.READ_LAT(1), .ADDR_W(16)) u_lat1 (
        .clk(clk), .reset(reset), .pc(pc), .req(req), .req_ready(d1_rr), .flush(flush),
        .mem_en(d1_en), .mem_ren(d1_ren), .mem_wen(d1_wen), .mem_addr(d1_addr),
        .mem_dout(d1_dout), .instr(d1_instr), .instr_pc(d1_ipc), .instr_valid(d1_valid),
        .instr_ready(instr_ready), .addr_err(d1_err));

    fetch_unit #(.READ_LAT(15), .ADDR_W(16)) u_lat15 (
        .clk(clk), .reset(reset), .pc(pc), .req(req), .req_ready(d15_rr), .flush(flush),
        .mem_en(d15_en), .mem_ren(d15_ren), .mem_wen(d15_wen), .mem_addr(d15_addr),
        .mem_dout(d15_dout), .instr(d15_instr), .instr_pc(d15_ipc), .instr_valid(d15_valid),
        .instr_ready(instr_ready), .addr_err(d15_err));

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return (a == 16'd5) ? 32'h2008000A : {16'hC0DE, a};
    endfunction

    // Memory models: {ren, addr} delayed READ_LAT edges; data only while that read is live.
    logic [16:0] p3 [0:2];
    logic [16:0] p1 [0:0];
    logic [16:0] p15 [0:14];
    always @(posedge clk) begin
        p3[0]  <= {d3_ren, d3_addr};
        p1[0]  <= {d1_ren, d1_addr};
        p15[0] <= {d15_ren, d15_addr};
        for (int i = 2; i > 0; i--) p3[i] <= p3[i-1];
        for (int j = 14; j > 0; j--) p15[j] <= p15[j-1];
    end
    assign d3_dout  = p3[2][16]   ? mem_word(p3[2][15:0])   : 32'hDEADBEEF;
    assign d1_dout  = p1[0][16]   ? mem_word(p1[0][15:0])   : 32'hDEADBEEF;
    assign d15_dout = p15[14][16] ? mem_word(p15[14][15:0]) : 32'hDEADBEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        pc  = a;
        req = 1'b1;
        chk("issue_req_ready", {31'd0, d3_rr}, 32'd1);
        sb.push_back('{pc: a, data: mem_word(a[15:0]), due: edge_n + 1 + 4});
        step();
        req = 1'b0;
    endtask

    task automatic expect_valid(input string tag);
        exp_t e;
        int   n = 0;
        while (!d3_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, d3_valid}, 32'd1);
        chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_instr"}, d3_instr, e.data);
            chk({tag, "_instr_pc"}, d3_ipc, e.pc);
            chk({tag, "_latency_edge"}, 32'(edge_n), 32'(e.due));
        end
    endtask

    initial begin
        int f1, f3, f15, acc, seen;
        logic [31:0] v1, v3, v15;

        reset = 1'b1; req = 1'b0; flush = 1'b0; instr_ready = 1'b0; pc = 32'd0;
        repeat (2) step();
        chk("rst_req_ready", {31'd0, d3_rr}, 32'd1);
        chk("rst_valid", {31'd0, d3_valid}, 32'd0);
        chk("rst_mem", {29'd0, d3_en, d3_ren, d3_wen}, 32'd0);
        chk("rst_instr", d3_instr, 32'd0);
        chk("rst_err", {31'd0, d3_err}, 32'd0);
        reset = 1'b0;
        step();

        // Basic fetch
        issue(32'd5);
        chk("basic_mem_ctl", {29'd0, d3_en, d3_ren, d3_wen}, 32'b110);
        chk("basic_mem_addr", {16'd0, d3_addr}, 32'd5);
        req = 1'b1; pc = 32'd77;
        step();
        chk("wait_req_ignored_addr", {16'd0, d3_addr}, 32'd5);
        chk("wait_req_ready", {31'd0, d3_rr}, 32'd0);
        req = 1'b0;
        expect_valid("basic");
        chk("hold_mem_ctl", {30'd0, d3_en, d3_ren}, 32'd0);

        // Backpressure in HOLD
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_instr", d3_instr, 32'h2008000A);
            chk("bp_pc", d3_ipc, 32'd5);
            chk("bp_ctl", {30'd0, d3_valid, d3_rr}, 32'b10);
        end
        instr_ready = 1'b1;
        step();
        chk("bp_release", {30'd0, d3_valid, d3_rr}, 32'b01);

        // Back-to-back, req held through WAIT
        pc = 32'd5; req = 1'b1;
        sb.push_back('{pc: 32'd5, data: mem_word(16'd5), due: edge_n + 1 + 4});
        step();
        pc = 32'd6;
        expect_valid("b2b_first");
        chk("b2b_req_ready", {31'd0, d3_rr}, 32'd1);
        sb.push_back('{pc: 32'd6, data: mem_word(16'd6), due: edge_n + 1 + 4});
        step();
        req = 1'b0;
        chk("b2b_no_bubble", {29'd0, d3_valid, d3_en, d3_ren}, 32'b011);
        chk("b2b_addr", {16'd0, d3_addr}, 32'd6);
        expect_valid("b2b_second");
        step();
        chk("b2b_idle", {31'd0, d3_rr}, 32'd1);
        instr_ready = 1'b0;

        // Flush in WAIT at counter=1 with a concurrent request
        issue(32'd7);
        step();
        flush = 1'b1; req = 1'b1; pc = 32'd99;
        step();
        flush = 1'b0; req = 1'b0;
        sb.delete();
        chk("flush_state", {28'd0, d3_rr, d3_en, d3_ren, d3_valid}, 32'b1000);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (d3_valid) seen = 1;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        issue(32'd40);
        expect_valid("after_flush");

        // Flush in HOLD beats instr_ready and req
        instr_ready = 1'b1; req = 1'b1; flush = 1'b1; pc = 32'd50;
        #1;
        chk("flush_hold_req_ready", {31'd0, d3_rr}, 32'd0);
        step();
        flush = 1'b0; req = 1'b0; instr_ready = 1'b0;
        chk("flush_hold_state", {29'd0, d3_valid, d3_en, d3_rr}, 32'b001);

        // Out-of-range pc, then reset mid-WAIT
        issue(32'h0001_0003);
        chk("err_addr", {16'd0, d3_addr}, 32'd3);
        chk("err_flag", {31'd0, d3_err}, 32'd1);
        step();
        chk("err_sticky", {31'd0, d3_err}, 32'd1);
        reset = 1'b1; flush = 1'b1; req = 1'b1; instr_ready = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0; req = 1'b0; instr_ready = 1'b0;
        sb.delete();
        chk("mid_rst_ctl", {26'd0, d3_rr, d3_en, d3_ren, d3_wen, d3_valid, d3_err}, 32'b100000);
        chk("mid_rst_addr", {16'd0, d3_addr}, 32'd0);
        chk("mid_rst_instr", d3_instr, 32'd0);
        chk("mid_rst_ipc", d3_ipc, 32'd0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (d3_valid) seen = 1;
        end
        chk("mid_rst_no_valid", 32'(seen), 32'd0);

        // Latency sweep across READ_LAT 1/3/15
        reset = 1'b1;
        step();
        reset = 1'b0;
        pc = 32'h22; req = 1'b1;
        step();
        req = 1'b0;
        acc = edge_n;
        f1 = -1; f3 = -1; f15 = -1;
        v1 = 32'd0; v3 = 32'd0; v15 = 32'd0;
        for (int k = 0; k < 24; k++) begin
            step();
            if (d1_valid && f1 < 0) begin f1 = edge_n - acc; v1 = d1_instr; end
            if (d3_valid && f3 < 0) begin f3 = edge_n - acc; v3 = d3_instr; end
            if (d15_valid && f15 < 0) begin f15 = edge_n - acc; v15 = d15_instr; end
        end
        chk("sweep_lat1_edges", 32'(f1), 32'd2);
        chk("sweep_lat3_edges", 32'(f3), 32'd4);
        chk("sweep_lat15_edges", 32'(f15), 32'd16);
        chk("sweep_lat1_data", v1, 32'hC0DE0022);
        chk("sweep_lat3_data", v3, 32'hC0DE0022);
        chk("sweep_lat15_data", v15, 32'hC0DE0022);
        chk("sweep_lat15_pc", d15_ipc, 32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
